// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master; retries master errors and times out silent attempts.
// Latency: req->m_start 1 cycle, m_done/m_error->ack 1 cycle; requesters hold req until their one-cycle ack.
module i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                       clock,
  input  logic                       reset_L,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [7*NUM_REQ-1:0]       req_addr,
  input  logic [NUM_REQ-1:0]         req_rw,
  input  logic [8*NUM_REQ-1:0]       req_wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       ack_error,
  output logic [7:0]                 rdata,
  output logic                       m_start,
  output logic [6:0]                 m_addr,
  output logic                       m_rw,
  output logic [7:0]                 m_wdata,
  input  logic                       m_done,
  input  logic                       m_error,
  input  logic [7:0]                 m_rdata,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [GW-1:0]      last_grant, last_grant_nxt, grant_nxt, win, cand;
  logic               found;
  logic [2:0]         retry_cnt, retry_nxt;
  logic [TW-1:0]      tcnt, tcnt_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic               ack_error_nxt, m_start_nxt, m_rw_nxt, busy_nxt;
  logic [7:0]         rdata_nxt, m_wdata_nxt;
  logic [6:0]         m_addr_nxt;
  logic [6:0]         addr_arr  [NUM_REQ];
  logic [7:0]         wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*7 +: 7];
      wdata_arr[i] = req_wdata[i*8 +: 8];
    end
  end

  // Walk from farthest to nearest so the candidate closest to last_grant+1 wins.
  always_comb begin
    found = 1'b0;
    win   = last_grant;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant_id;
    retry_nxt      = retry_cnt;
    tcnt_nxt       = tcnt;
    ack_nxt        = '0;
    ack_error_nxt  = 1'b0;
    rdata_nxt      = 8'h00;
    m_start_nxt    = 1'b0;
    m_addr_nxt     = m_addr;
    m_rw_nxt       = m_rw;
    m_wdata_nxt    = m_wdata;
    case (state)
      IDLE: begin
        if (found) begin
          m_addr_nxt  = addr_arr[win];
          m_rw_nxt    = req_rw[win];
          m_wdata_nxt = wdata_arr[win];
          grant_nxt   = win;
          retry_nxt   = 3'd0;
          tcnt_nxt    = '0;
          m_start_nxt = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Error wins over a coincident done.
        if (m_error) begin
          if (int'(retry_cnt) < MAX_RETRY) begin
            retry_nxt   = retry_cnt + 3'd1;
            m_start_nxt = 1'b1;
            state_nxt   = ISSUE;
          end else begin
            ack_nxt[grant_id] = 1'b1;
            ack_error_nxt     = 1'b1;
            state_nxt         = RESP;
          end
        end else if (m_done) begin
          ack_nxt[grant_id] = 1'b1;
          rdata_nxt         = m_rw ? m_rdata : 8'h00;
          state_nxt         = RESP;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          ack_nxt[grant_id] = 1'b1;
          ack_error_nxt     = 1'b1;
          state_nxt         = RESP;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      RESP: begin
        last_grant_nxt = grant_id;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      retry_cnt  <= 3'd0;
      tcnt       <= '0;
      ack        <= '0;
      ack_error  <= 1'b0;
      rdata      <= 8'h00;
      m_start    <= 1'b0;
      m_addr     <= 7'h00;
      m_rw       <= 1'b0;
      m_wdata    <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_nxt;
      retry_cnt  <= retry_nxt;
      tcnt       <= tcnt_nxt;
      ack        <= ack_nxt;
      ack_error  <= ack_error_nxt;
      rdata      <= rdata_nxt;
      m_start    <= m_start_nxt;
      m_addr     <= m_addr_nxt;
      m_rw       <= m_rw_nxt;
      m_wdata    <= m_wdata_nxt;
      busy       <= busy_nxt;
    end
  end
endmodule
